ifetch_queue: RTL

//  Decoupled instruction fetch unit: keeps up to MAX_OUTSTANDING in-order requests in flight to imem and

---
 rtl/ifetch_pkg.sv | 32 +++
 rtl/ifetch_fifo.sv | 57 +++++
 rtl/ifetch_queue.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch queue: queue entry and in-flight tag
// layouts, the fetch FSM state encoding, and the response word selector.
package ifetch_pkg;

  localparam int unsigned PC_W        = 64;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned IMEM_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } ifetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               fault;
  } fetch_entry_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            epoch;
  } fetch_tag_t;

  // imem returns a doubleword; PC bit 2 picks the upper or lower instruction.
  function automatic logic [INSTR_W-1:0] select_instr(input logic [IMEM_DATA_W-1:0] rdata,
                                                      input logic                   upper);
    return upper ? rdata[63:32] : rdata[31:0];
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Generic synchronous FIFO with synchronous clear and asynchronous active-low
// reset. DEPTH need not be a power of two. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module ifetch_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy tracking; clear empties the FIFO regardless of push/pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= bump(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= bump(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage array; contents are only observed through valid occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled instruction fetch: issues in-order imem requests (bounded by
// MAX_OUTSTANDING and by queue credit), tags each with the fetch epoch, and
// buffers epoch-matching responses for decode. A redirect flushes the queue,
// toggles the epoch so in-flight responses are discarded, and reloads the PC.
// Optional feature macro: IFETCH_FAULT_EN (imem_err produces a fault entry and
// halts fetch until the next redirect).
module ifetch_queue import ifetch_pkg::*; #(
  parameter int unsigned     XLEN            = 64,
  parameter int unsigned     ADDR_W          = 32,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [IMEM_DATA_W-1:0] imem_rdata,
  input  logic                   imem_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic                   out_fault
);

  localparam int unsigned OS_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned Q_W  = $clog2(FIFO_DEPTH + 1);

  ifetch_state_t      state_q, state_d;
  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic               epoch_q, epoch_d;
  logic [OS_W-1:0]    outstanding;
  logic [Q_W-1:0]     q_count;
  fetch_tag_t         tag_in, tag_head;
  fetch_entry_t       ent_in, ent_head;
  logic               fire, rsp_keep, rsp_fault, fault_push, out_pop;
  logic [INSTR_W-1:0] rsp_instr;

  // Outstanding requests plus queued entries never exceed FIFO_DEPTH, so every
  // response that arrives has a guaranteed slot in the out queue.
  assign imem_req = (state_q == RUN) && !redirect_valid
                    && (32'(outstanding) < MAX_OUTSTANDING)
                    && ((32'(outstanding) + 32'(q_count)) < FIFO_DEPTH);
  assign imem_addr = {fetch_pc_q[ADDR_W-1:2], 2'b00};
  assign fire      = imem_req && imem_gnt;

  assign tag_in.pc    = PC_W'(fetch_pc_q);
  assign tag_in.epoch = epoch_q;

  ifetch_fifo #(
    .WIDTH($bits(fetch_tag_t)),
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_q (
    .clk    (clk),
    .resetn (resetn),
    .clear_i(1'b0),
    .push_i (fire),
    .pop_i  (imem_rvalid),
    .data_i (tag_in),
    .data_o (tag_head),
    .count_o(outstanding)
  );

`ifdef IFETCH_FAULT_EN
  assign rsp_fault = imem_err;
  assign rsp_instr = imem_err ? '0 : select_instr(imem_rdata, tag_head.pc[2]);
`else
  logic unused_err;
  assign unused_err = imem_err;
  assign rsp_fault  = 1'b0;
  assign rsp_instr  = select_instr(imem_rdata, tag_head.pc[2]);
`endif

  // Responses from a previous epoch, or arriving during a redirect, are dropped.
  assign rsp_keep   = imem_rvalid && (tag_head.epoch == epoch_q) && !redirect_valid;
  assign fault_push = rsp_keep && rsp_fault;
  assign out_pop    = out_valid && out_ready && !redirect_valid;

  assign ent_in.pc    = tag_head.pc;
  assign ent_in.instr = rsp_instr;
  assign ent_in.fault = rsp_fault;

  ifetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_out_q (
    .clk    (clk),
    .resetn (resetn),
    .clear_i(redirect_valid),
    .push_i (rsp_keep),
    .pop_i  (out_pop),
    .data_i (ent_in),
    .data_o (ent_head),
    .count_o(q_count)
  );

  assign out_valid = (q_count != '0);
  assign out_instr = out_valid ? ent_head.instr : '0;
  assign out_pc    = out_valid ? ent_head.pc[XLEN-1:0] : '0;
  assign out_fault = out_valid && ent_head.fault;

  // Fetch state, PC and epoch registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      epoch_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
    end
  end

  // Next state: a redirect leaves IDLE alone but moves RUN/HALT per fetch_en.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      if (state_q != IDLE) state_d = fetch_en ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (fetch_en) state_d = RUN;
        RUN: begin
          if (fault_push)     state_d = HALT;
          else if (!fetch_en) state_d = IDLE;
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // PC advance on accepted request; redirect reloads the PC and flips the epoch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    epoch_d    = epoch_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      epoch_d    = ~epoch_q;
    end else if (fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

endmodule
